// File: rtl/led_pwm_dimmer_if.sv
// Register-write bus for led_pwm_dimmer: one-cycle write strobe with address and data.
interface led_pwm_dimmer_if #(
  parameter int unsigned AW       = 5,
  parameter int unsigned PWM_BITS = 8
);
  logic                wr_en;
  logic [AW-1:0]       wr_addr;
  logic [PWM_BITS-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/led_pwm_dimmer.sv
// Multi-channel LED PWM with double-buffered duties applied at period boundaries.
// Define LED_PWM_FADE_EN to add the fade_rate register and gradual duty fading.
module led_pwm_dimmer #(
  parameter int unsigned CHANNELS = 3,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned PRESCALE = 16,
  parameter int unsigned AW       = 5
) (
  input  logic                clk,
  input  logic                reset_n,
  led_pwm_dimmer_if.slave     bus,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start,
  output logic                fade_busy
);

  localparam int unsigned PSW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PSW-1:0]      presc;
  logic [PWM_BITS-1:0] cnt;
  logic                en_q;
  logic                en_d;
  logic [PWM_BITS-1:0] shadow [CHANNELS];
  logic [PWM_BITS-1:0] active [CHANNELS];

  logic tick_c;
  logic boundary_c;
  logic ctrl_wr_c;

  assign tick_c     = (presc == PSW'(PRESCALE - 1));
  // Period boundary: counter wrap, or first enabled cycle after enable rises.
  assign boundary_c = en_q & ((tick_c & (cnt == '1)) | ~en_d);
  assign ctrl_wr_c  = bus.wr_en & (bus.wr_addr == AW'(CHANNELS));

  // Timebase, control register, shadow duties and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      presc        <= '0;
      cnt          <= '0;
      en_q         <= 1'b0;
      en_d         <= 1'b0;
      period_start <= 1'b0;
      pwm_out      <= '0;
      for (int unsigned n = 0; n < CHANNELS; n++) shadow[n] <= '0;
    end else begin
      en_d         <= en_q;
      period_start <= boundary_c;
      if (ctrl_wr_c) en_q <= bus.wr_data[0];
      for (int unsigned n = 0; n < CHANNELS; n++) begin
        if (bus.wr_en && (bus.wr_addr == AW'(n))) shadow[n] <= bus.wr_data;
        pwm_out[n] <= en_q & (cnt < active[n]);
      end
      if (en_q) begin
        presc <= tick_c ? '0 : presc + PSW'(1);
        if (tick_c) cnt <= cnt + PWM_BITS'(1);
      end else begin
        presc <= '0;
        cnt   <= '0;
      end
    end
  end

`ifdef LED_PWM_FADE_EN
  logic [PWM_BITS-1:0] fade_rate;
  logic [PWM_BITS-1:0] fade_div;
  logic                rate_wr_c;
  logic                fade_step_c;
  logic                busy_c;

  assign rate_wr_c   = bus.wr_en & (bus.wr_addr == AW'(CHANNELS + 1));
  assign fade_step_c = (fade_div == fade_rate - PWM_BITS'(1));

  always_comb begin
    busy_c = 1'b0;
    for (int unsigned n = 0; n < CHANNELS; n++) busy_c = busy_c | (active[n] != shadow[n]);
  end

  // Active duties move one LSB toward shadow every fade_rate boundaries.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fade_rate <= '0;
      fade_div  <= '0;
      fade_busy <= 1'b0;
      for (int unsigned n = 0; n < CHANNELS; n++) active[n] <= '0;
    end else begin
      fade_busy <= busy_c;
      if (rate_wr_c) begin
        fade_rate <= bus.wr_data;
        fade_div  <= '0;
      end else if (boundary_c && (fade_rate != '0)) begin
        fade_div <= fade_step_c ? '0 : fade_div + PWM_BITS'(1);
      end
      if (boundary_c) begin
        for (int unsigned n = 0; n < CHANNELS; n++) begin
          if (fade_rate == '0) begin
            active[n] <= shadow[n];
          end else if (fade_step_c) begin
            if (active[n] < shadow[n])      active[n] <= active[n] + PWM_BITS'(1);
            else if (active[n] > shadow[n]) active[n] <= active[n] - PWM_BITS'(1);
          end
        end
      end
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned n = 0; n < CHANNELS; n++) active[n] <= '0;
    end else if (boundary_c) begin
      for (int unsigned n = 0; n < CHANNELS; n++) active[n] <= shadow[n];
    end
  end

  assign fade_busy = 1'b0;
`endif

endmodule

// File: tb/tb_led_pwm_dimmer.sv
// Self-checking bench for led_pwm_dimmer: directed test-plan steps plus random writes against a period-level model.
module tb_led_pwm_dimmer;
  localparam int unsigned CH  = 3;
  localparam int unsigned PB  = 4;
  localparam int unsigned PS  = 2;
  localparam int unsigned AW  = 5;
  localparam int          PER = PS * (1 << PB);

  logic          clk = 1'b0;
  logic          reset_n;
  logic [CH-1:0] pwm_out;
  logic          period_start;
  logic          fade_busy;

  led_pwm_dimmer_if #(.AW(AW), .PWM_BITS(PB)) bus ();

  led_pwm_dimmer #(.CHANNELS(CH), .PWM_BITS(PB), .PRESCALE(PS), .AW(AW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .bus          (bus),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .fade_busy    (fade_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: position within the period as one enabled-cycle index.
  logic          m_en, m_enp;
  int            m_t;
  logic [PB-1:0] m_sh  [CH];
  logic [PB-1:0] m_act [CH];
  int            m_rate, m_bcnt;
  logic [CH-1:0] e_pwm;
  logic          e_ps, e_busy;
  int            w_hi [CH];
  int            w_ps;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic rn, input logic we, input logic [AW-1:0] a, input logic [PB-1:0] d);
    logic bnd;
    if (!rn) begin
      m_en = 0; m_enp = 0; m_t = 0; m_rate = 0; m_bcnt = 0;
      e_pwm = '0; e_ps = 0; e_busy = 0;
      for (int n = 0; n < CH; n++) begin m_sh[n] = '0; m_act[n] = '0; end
      return;
    end
    bnd = m_en && (!m_enp || m_t == PER - 1);
    for (int n = 0; n < CH; n++) e_pwm[n] = m_en && ((m_t / PS) < int'(m_act[n]));
    e_ps   = bnd;
    e_busy = 0;
`ifdef LED_PWM_FADE_EN
    for (int n = 0; n < CH; n++) if (m_act[n] != m_sh[n]) e_busy = 1;
`endif
    if (bnd) begin
      if (m_rate == 0) begin
        for (int n = 0; n < CH; n++) m_act[n] = m_sh[n];
      end else begin
        m_bcnt++;
        if (m_bcnt == m_rate) begin
          m_bcnt = 0;
          for (int n = 0; n < CH; n++) begin
            if (m_act[n] < m_sh[n])      m_act[n] = m_act[n] + PB'(1);
            else if (m_act[n] > m_sh[n]) m_act[n] = m_act[n] - PB'(1);
          end
        end
      end
    end
    m_t   = m_en ? (m_t + 1) % PER : 0;
    m_enp = m_en;
    if (we) begin
      if (int'(a) < CH) m_sh[a] = d;
      else if (int'(a) == CH) m_en = d[0];
`ifdef LED_PWM_FADE_EN
      else if (int'(a) == CH + 1) begin m_rate = int'(d); m_bcnt = 0; end
`endif
    end
  endtask

  task automatic cyc(input logic rn, input logic we, input logic [AW-1:0] a, input logic [PB-1:0] d);
    reset_n     = rn;
    bus.wr_en   = we;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(posedge clk);
    model_step(rn, we, a, d);
    #1;
    chk("pwm_out", 32'(pwm_out), 32'(e_pwm));
    chk("period_start", 32'(period_start), 32'(e_ps));
    chk("fade_busy", 32'(fade_busy), 32'(e_busy));
    for (int n = 0; n < CH; n++) w_hi[n] += int'(pwm_out[n]);
    w_ps += int'(period_start);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1, 0, '0, '0);
  endtask

  task automatic wr(input int a, input int d);
    cyc(1, 1, AW'(a), PB'(d));
  endtask

  task automatic clr_win();
    for (int n = 0; n < CH; n++) w_hi[n] = 0;
    w_ps = 0;
  endtask

  task automatic wait_t(input int target);
    for (int i = 0; i < 2 * PER && m_t != target; i++) idle(1);
    chk("wait_t", 32'(m_t), 32'(target));
  endtask

  initial begin
    reset_n = 0; bus.wr_en = 0; bus.wr_addr = '0; bus.wr_data = '0;
    clr_win();

    // Reset state
    for (int i = 0; i < 3; i++) cyc(0, 0, '0, '0);
    chk("rst_pwm", 32'(pwm_out), 0);
    chk("rst_ps", 32'(period_start), 0);
    chk("rst_busy", 32'(fade_busy), 0);

    // Duties 4/8/15 then enable
    wr(0, 4); wr(1, 8); wr(2, 15); wr(CH, 1);
    idle(40);
    clr_win(); idle(PER);
    chk("d4_hi", 32'(w_hi[0]), 8);
    chk("d8_hi", 32'(w_hi[1]), 16);
    chk("d15_hi", 32'(w_hi[2]), 30);
    chk("win_ps", 32'(w_ps), 1);

    // Duty 0 stays low for 4 periods
    wr(0, 0);
    idle(40);
    clr_win(); idle(4 * PER);
    chk("d0_hi", 32'(w_hi[0]), 0);
    chk("d15_4p_hi", 32'(w_hi[2]), 120);
    chk("ps_4p", 32'(w_ps), 4);

    // Mid-period write, then a write coincident with the wrap tick
    wait_t(16);
    wr(1, 2);
    wait_t(PER - 1);
    wr(1, 6);
    clr_win(); idle(PER);
    chk("mid_wr_hi", 32'(w_hi[1]), 4);
    clr_win(); idle(PER);
    chk("coinc_wr_hi", 32'(w_hi[1]), 12);

    // Disable mid-period, then re-enable
    wait_t(10);
    wr(CH, 0);
    idle(1);
    chk("dis_pwm", 32'(pwm_out), 0);
    clr_win(); idle(20);
    chk("dis_ps", 32'(w_ps), 0);
    wr(CH, 1);
    idle(1);
    chk("reen_ps", 32'(period_start), 1);
    idle(40);
    clr_win(); idle(PER);
    chk("reen_hi1", 32'(w_hi[1]), 12);
    chk("reen_hi2", 32'(w_hi[2]), 30);

    // Reset for one clk with an output high
    for (int i = 0; i < PER && pwm_out[2] !== 1'b1; i++) idle(1);
    chk("pre_rst_high", 32'(pwm_out[2]), 1);
    cyc(0, 0, '0, '0);
    chk("mrst_pwm", 32'(pwm_out), 0);
    chk("mrst_ps", 32'(period_start), 0);
    wr(CH, 1);
    idle(40);
    clr_win(); idle(PER);
    chk("mrst_hi", 32'(w_hi[0] + w_hi[1] + w_hi[2]), 0);
    chk("mrst_win_ps", 32'(w_ps), 1);

`ifdef LED_PWM_FADE_EN
    // Fade: rate 2, ch0 from 0 to 3
    cyc(0, 0, '0, '0);
    wr(CH, 1); wr(CH + 1, 2); wr(0, 3);
    idle(4);
    chk("fade_busy_on", 32'(fade_busy), 1);
    idle(8 * PER);
    chk("fade_busy_off", 32'(fade_busy), 0);
    clr_win(); idle(PER);
    chk("fade_hi", 32'(w_hi[0]), 6);
    wr(CH + 1, 0);
`else
    // Fade register and unmapped addresses are ignored
    wr(0, 1); wr(1, 2); wr(2, 3);
    wr(CH + 1, 5); wr(7, 9);
    idle(40);
    clr_win(); idle(PER);
    chk("nofade_hi0", 32'(w_hi[0]), 2);
    chk("nofade_hi1", 32'(w_hi[1]), 4);
    chk("nofade_hi2", 32'(w_hi[2]), 6);
`endif

    // Random writes and occasional resets against the model
    wr(CH, 1);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) cyc(0, 0, '0, '0);
      else if ($urandom_range(0, 7) == 0)
        cyc(1, 1, AW'($urandom_range(0, 7)), PB'($urandom));
      else idle(1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
